// File: rtl/core_run_sequencer.sv
// Bring-up and run sequencer for a bank of datapath cores:
// staggered reset release, start strobe, done collection, timeout guard.
module core_run_sequencer #(
  parameter int NUM_CORES = 4,
  parameter int RST_HOLD  = 8,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 userReset,
  input  logic                 runReq,
  input  logic [NUM_CORES-1:0] coreDone,
  output logic [NUM_CORES-1:0] coreReset,
  output logic                 coreStart,
  output logic                 ready,
  output logic                 busy,
  output logic                 runDone,
  output logic                 timeoutErr,
  output logic [NUM_CORES-1:0] doneMask
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_RELEASE,
    S_READY,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state;
  state_t               stateNxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cntNxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idxNxt;
  logic [NUM_CORES-1:0] coreResetNxt;
  logic [NUM_CORES-1:0] doneMaskNxt;
  logic                 timeoutErrNxt;
  logic [NUM_CORES-1:0] doneSeen;

  assign doneSeen = doneMask | coreDone;

  // Falling-edge state; reset must reach the cores without waiting for a clock
  always_ff @(negedge clock or negedge userReset) begin
    if (!userReset) begin
      state      <= S_RESET;
      cnt        <= '0;
      idx        <= '0;
      coreReset  <= '1;
      doneMask   <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      idx        <= idxNxt;
      coreReset  <= coreResetNxt;
      doneMask   <= doneMaskNxt;
      timeoutErr <= timeoutErrNxt;
    end
  end

  always_comb begin
    stateNxt      = state;
    cntNxt        = cnt;
    idxNxt        = idx;
    coreResetNxt  = coreReset;
    doneMaskNxt   = doneMask;
    timeoutErrNxt = timeoutErr;
    unique case (state)
      S_RESET: begin
        stateNxt = S_RELEASE;
        cntNxt   = '0;
        idxNxt   = '0;
      end
      S_RELEASE: begin
        if (cnt == HOLD_LAST) begin
          coreResetNxt[idx] = 1'b0;
          idxNxt            = idx + IDX_W'(1);
          cntNxt            = '0;
          if (idx == IDX_LAST) begin
            stateNxt = S_READY;
          end
        end else begin
          cntNxt = cnt + CNT_W'(1);
        end
      end
      S_READY: begin
        if (runReq) begin
          stateNxt      = S_START;
          doneMaskNxt   = '0;
          timeoutErrNxt = 1'b0;
        end
      end
      S_START: begin
        stateNxt = S_WAIT;
        cntNxt   = '0;
      end
      S_WAIT: begin
        doneMaskNxt = doneSeen;
        cntNxt      = cnt + CNT_W'(1);
        // A last done on the timeout edge still counts as success
        if (&doneSeen) begin
          stateNxt = S_DONE;
        end else if (cnt == TO_LAST) begin
          stateNxt      = S_ERROR;
          timeoutErrNxt = 1'b1;
          coreResetNxt  = '1;
        end
      end
      S_DONE: begin
        stateNxt = S_READY;
      end
      S_ERROR: begin
        stateNxt = S_RELEASE;
        cntNxt   = '0;
        idxNxt   = '0;
      end
      default: begin
        stateNxt = S_RESET;
      end
    endcase
  end

  assign coreStart = (state == S_START);
  assign ready     = (state == S_READY);
  assign runDone   = (state == S_DONE);
  assign busy      = (state == S_START) ||
                     (state == S_WAIT)  ||
                     (state == S_DONE);

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer: vector table for the run
// handshake plus hand-written bring-up, timeout and reset sequences.
module tb_core_run_sequencer;

  localparam int NC = 4;

  logic          clock;
  logic          userReset;
  logic          runReq;
  logic [NC-1:0] coreDone;
  logic [NC-1:0] coreReset;
  logic          coreStart;
  logic          ready;
  logic          busy;
  logic          runDone;
  logic          timeoutErr;
  logic [NC-1:0] doneMask;

  int checks = 0;
  int errors = 0;

  core_run_sequencer #(
    .NUM_CORES(NC),
    .RST_HOLD (8),
    .TIMEOUT  (32),
    .CNT_W    (16)
  ) dut (
    .clock     (clock),
    .userReset (userReset),
    .runReq    (runReq),
    .coreDone  (coreDone),
    .coreReset (coreReset),
    .coreStart (coreStart),
    .ready     (ready),
    .busy      (busy),
    .runDone   (runDone),
    .timeoutErr(timeoutErr),
    .doneMask  (doneMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          rr;
    logic [NC-1:0] cd;
    logic          rdy;
    logic          bsy;
    logic          st;
    logic          rd;
    logic          te;
    logic [NC-1:0] dm;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Drive at a rising edge; one falling (active) edge passes before return
  task automatic step(input logic rr, input logic [NC-1:0] cd);
    runReq   = rr;
    coreDone = cd;
    @(posedge clock);
  endtask

  task automatic chkAll(input string tag, input logic rdy, input logic bsy,
                        input logic st, input logic rd, input logic te,
                        input logic [NC-1:0] dm, input logic [NC-1:0] cr);
    chk({tag, ".ready"}, 16'(ready), 16'(rdy));
    chk({tag, ".busy"}, 16'(busy), 16'(bsy));
    chk({tag, ".coreStart"}, 16'(coreStart), 16'(st));
    chk({tag, ".runDone"}, 16'(runDone), 16'(rd));
    chk({tag, ".timeoutErr"}, 16'(timeoutErr), 16'(te));
    chk({tag, ".doneMask"}, 16'(doneMask), 16'(dm));
    chk({tag, ".coreReset"}, 16'(coreReset), 16'(cr));
  endtask

  // From RESET or ERROR: entry edge, then 32 edges of staggered release
  task automatic releaseSeq(input string tag, input logic rr);
    logic [NC-1:0] exp;
    step(rr, '0);
    chk({tag, ".entryReset"}, 16'(coreReset), 16'hF);
    chk({tag, ".entryReady"}, 16'(ready), 16'h0);
    for (int k = 1; k <= 32; k++) begin
      step(rr, '0);
      exp = NC'(4'hF << (k / 8));
      if (k % 8 == 0 || k % 8 == 7) begin
        chk($sformatf("%s.coreReset@%0d", tag, k), 16'(coreReset), 16'(exp));
        chk($sformatf("%s.ready@%0d", tag, k), 16'(ready), 16'(k == 32));
      end
      chk($sformatf("%s.noStart@%0d", tag, k), 16'(coreStart), 16'h0);
    end
  endtask

  initial begin
    userReset = 1'b1;
    runReq    = 1'b0;
    coreDone  = '0;

    tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    tbl[4]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    tbl[5]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    tbl[6]  = '{1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
    tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
    tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
    tbl[10] = '{1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF};
    tbl[12] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[13] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[14] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    tbl[15] = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF};
    tbl[16] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[18] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    tbl[19] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF};

    // Power-up: reset low for three cycles
    #1 userReset = 1'b0;
    repeat (3) @(posedge clock);
    chkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
    userReset = 1'b1;
    releaseSeq("powerup", 1'b0);
    chkAll("powerupDone", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Normal runs, ignored requests in WAIT/DONE, level runReq in READY
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rr, tbl[i].cd);
      chkAll($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].bsy, tbl[i].st,
             tbl[i].rd, tbl[i].te, tbl[i].dm, 4'h0);
    end

    // Timeout: cores 0 and 2 report, 1 and 3 stay silent
    step(1'b1, '0);
    chkAll("toStart", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, '0);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, (k == 3) ? 4'h5 : 4'h0);
      if (k == 31)
        chkAll("toWait31", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0);
    end
    chkAll("toError", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'hF);
    releaseSeq("rerelease", 1'b1);
    chkAll("rereleaseDone", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h0);
    step(1'b1, '0);
    chkAll("clearErr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

    // Last done on the same edge the timeout would fire
    step(1'b0, '0);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, (k == 1) ? 4'h7 : ((k == 32) ? 4'h8 : 4'h0));
      if (k == 31)
        chkAll("simWait31", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h0);
    end
    chkAll("simDone", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    step(1'b0, '0);
    chkAll("simReady", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0);

    // Asynchronous reset in the middle of WAIT
    step(1'b1, '0);
    step(1'b0, '0);
    step(1'b0, 4'h1);
    chkAll("midWait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
    #2 userReset = 1'b0;
    #1;
    chkAll("midReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
    @(posedge clock);
    chkAll("midHeld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
    userReset = 1'b1;
    releaseSeq("rebring", 1'b0);
    chkAll("rebringDone", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
